video_timing_meter: RTL
=======================

# video_timing_meter

Measures the timing of the sync/DE stream leaving the ADV7611 frontend: line and frame totals, sync widths, back porches, active sizes and interlace status. It sits directly downstream of the frontend, on the same pixel clock. Firmware reads the results to program the frontend's horizontal and vertical timing configuration, and uses the stability and timeout flags to detect mode changes and signal loss.

## Interface
- STABLE_FRAMES, 3: consecutive identical frames required before `stable` asserts (1..15).
- TIMEOUT_CLKS, 4194304: clocks without a VSYNC falling edge before `timeout` asserts.

Ports:
- PCLK_i  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  measurement enable; low forces IDLE.
- HSYNC_i  in  1  active-low hsync from the frontend.
- VSYNC_i  in  1  active-low vsync from the frontend.
- DE_i  in  1  active-high data enable from the frontend.
- h_total  out  12  clocks per line.
- h_synclen  out  8  hsync width in clocks.
- h_backporch  out  9  clocks from hsync rise to DE rise.
- h_active  out  12  DE-high clocks per line.
- v_total  out  11  lines per field.
- v_synclen  out  4  vsync width in lines.
- v_backporch  out  9  lines from the vsync-end line to the first DE line.
- v_active  out  11  lines containing DE per field.
- interlace  out  1  consecutive fields differ in v_total by exactly 1.
- meas_valid  out  1  at least one complete field has been measured.
- stable  out  1  measurements have been unchanged for STABLE_FRAMES fields.
- timeout  out  1  no VSYNC falling edge within TIMEOUT_CLKS.

## Operation
- Edge detection compares each input with its value registered on the previous clock.
  - HS fall is HSYNC_prev high and HSYNC_i low; this is position 0 of a line.
  - HS rise, VS fall, DE rise and DE fall are detected the same way.
- Position counter `hpos`:
  - Set to 0 on HS fall, otherwise incremented.
  - Saturates at 4095.
- Line counter `vline`:
  - Set to 0 on the HS fall that coincides with VS fall, or on the first HS fall after a VS fall.
  - Incremented on every other HS fall.
  - Saturates at 2047.
- Per-line captures:
  - Position of HS rise gives synclen.
  - Position of DE rise minus synclen gives backporch.
  - DE fall position minus DE rise position gives active.
  - `hpos+1` latched at the next HS fall gives total.
- The horizontal outputs are taken from the last line in the field that contained a DE rise.
- Vertical captures:
  - v_synclen is the number of HS falls sampled with VSYNC_i low.
  - v_backporch is the first DE line minus v_synclen.
  - v_active is the number of lines containing a DE rise.
  - v_total is `vline+1` at VS fall.
- Capture fields clip to their port widths: synclen ≤255, backporch ≤511, v_synclen ≤15.
- FSM:
  - IDLE: outputs are held. Exits to WAIT_VS when `enable` is high.
  - WAIT_VS: discards the partial field. Goes to RUN on VS fall.
  - RUN: on each VS fall, all outputs update together and the field restarts.
  - Any state goes to IDLE when `enable` is low. IDLE clears `stable` and the match counter but keeps the measured values.
- Stability:
  - `match_cnt` increments (saturating) when a field's eight values equal the previous field's. The v_total compare ignores a ±1 difference while `interlace` is set.
  - Any other mismatch clears `match_cnt` to 0.
  - `stable` = `match_cnt ≥ STABLE_FRAMES`.
- Interlace is set when |v_total(n) − v_total(n−1)| = 1, and cleared otherwise.
- Timeout:
  - A watchdog counter is cleared on VS fall and saturates at TIMEOUT_CLKS.
  - On reaching TIMEOUT_CLKS: `timeout`=1, `stable`=0, `meas_valid`=0, FSM goes to WAIT_VS.
  - `timeout` clears on the next VS fall.

## Timing
- Reset:
  - All outputs are 0 and the FSM is IDLE. Reset asserted mid-field discards the field.
  - After reset, the first VS fall only starts the first field; outputs first update at the second VS fall.
- Latency: outputs change on the clock edge one cycle after the clock where VS fall is detected, i.e. two clocks after VSYNC_i is first sampled low.
  - `meas_valid`, `stable` and `interlace` update on the same edge as the values.
- Simultaneous HS fall and VS fall: the line counts as line 0 of the new field, and the previous line's h_total is still latched into the field being closed.
- DE never high in a field: h_backporch, h_active and v_active are reported as 0 and v_backporch as 0; h_total, h_synclen, v_total and v_synclen remain valid.

## Test plan
- 720p (1650/40/220/1280, 750/5/20/720), 5 fields → after the 2nd VS fall, outputs read 1650, 40, 220, 1280, 750, 5, 20, 720; `meas_valid`=1; `stable`=1 after the 5th.
- Synthetic mode 100/8/12/64 with 30/2/4/20 → exact values; `stable` asserts after STABLE_FRAMES+1 fields and never before.
- Alternating v_total 262/263 fields → `interlace`=1 from the 3rd field on; `stable` still asserts.
- Mode switch 720p→synthetic mid-stream → `stable` drops at the first changed field, and values update at that field.
- Hold VSYNC_i high for TIMEOUT_CLKS → `timeout`=1, `stable`=0, `meas_valid`=0; restart → `timeout`=0 at the first VS fall.
- Assert reset mid-field, and deassert `enable` mid-field → outputs zeroed by reset; `stable`=0 but values kept with `enable` low.

Source files
------------

// File: rtl/video_timing_meter.sv
// Measures line/frame timing of an active-low HSYNC/VSYNC plus DE stream.
// Results for a field are published together one clock after its closing VSYNC falling edge.
module video_timing_meter #(
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT_CLKS  = 4194304
) (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic        enable,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    input  logic        DE_i,
    output logic [11:0] h_total,
    output logic [7:0]  h_synclen,
    output logic [8:0]  h_backporch,
    output logic [11:0] h_active,
    output logic [10:0] v_total,
    output logic [3:0]  v_synclen,
    output logic [8:0]  v_backporch,
    output logic [10:0] v_active,
    output logic        interlace,
    output logic        meas_valid,
    output logic        stable,
    output logic        timeout
);

    localparam int              WDW      = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [WDW-1:0]  WD_MAX   = WDW'(TIMEOUT_CLKS);
    localparam logic [WDW-1:0]  WD_HIT   = WDW'(TIMEOUT_CLKS - 1);
    localparam logic [3:0]      STABLE_N = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_RUN} state_t;

    state_t          r_state;
    logic            r_hs_prev, r_vs_prev, r_de_prev;
    logic [11:0]     r_hpos;
    logic [10:0]     r_vline;
    logic            r_vs_pend;
    logic [7:0]      r_cur_synclen;
    logic [8:0]      r_cur_bp;
    logic [11:0]     r_cur_rise, r_cur_active;
    logic            r_cur_de;
    logic [11:0]     r_f_htotal, r_f_active;
    logic [7:0]      r_f_synclen;
    logic [8:0]      r_f_bp;
    logic            r_f_de_seen;
    logic [10:0]     r_f_first, r_f_vactive;
    logic [3:0]      r_f_vsync;
    logic [11:0]     r_s_htotal, r_s_active;
    logic [7:0]      r_s_synclen;
    logic [8:0]      r_s_bp, r_s_vbp;
    logic [10:0]     r_s_vtotal, r_s_vactive;
    logic [3:0]      r_s_vsync;
    logic            r_close, r_vs_fall_d;
    logic [3:0]      r_match;
    logic [WDW-1:0]  r_wdog;

    logic            w_hs_fall, w_hs_rise, w_vs_fall, w_de_rise, w_de_fall;
    logic [11:0]     w_hpos_inc, w_hpos, w_bp_full, w_act;
    logic [10:0]     w_vline_inc, w_vline, w_vbp_full;
    logic [7:0]      w_sync_clip;
    logic [8:0]      w_bp_clip, w_vbp_cap;
    logic            w_hs_upd, w_de_upd;
    logic [11:0]     w_nx_htotal, w_nx_active;
    logic [7:0]      w_nx_synclen;
    logic [8:0]      w_nx_bp;
    logic            w_vt_diff1, w_vt_match, w_same, w_wdog_hit;
    logic [3:0]      w_match_nx;

    assign w_hs_fall  = r_hs_prev & ~HSYNC_i;
    assign w_hs_rise  = ~r_hs_prev & HSYNC_i;
    assign w_vs_fall  = r_vs_prev & ~VSYNC_i;
    assign w_de_rise  = ~r_de_prev & DE_i;
    assign w_de_fall  = r_de_prev & ~DE_i;
    assign w_wdog_hit = (r_state != S_IDLE) && !w_vs_fall && (r_wdog == WD_HIT);

    // Position counters, clipped captures and the field values as they stand after this clock's HS fall
    always_comb begin
        w_hpos_inc  = (r_hpos == 12'd4095) ? r_hpos : r_hpos + 12'd1;
        w_hpos      = w_hs_fall ? 12'd0 : w_hpos_inc;
        w_vline_inc = (r_vline == 11'd2047) ? r_vline : r_vline + 11'd1;
        if (w_hs_fall) begin
            w_vline = (w_vs_fall || r_vs_pend) ? 11'd0 : w_vline_inc;
        end else begin
            w_vline = r_vline;
        end
        w_sync_clip = (w_hpos > 12'd255) ? 8'd255 : w_hpos[7:0];
        w_bp_full   = w_hpos - {4'd0, r_cur_synclen};
        if (w_hpos < {4'd0, r_cur_synclen}) begin
            w_bp_clip = 9'd0;
        end else begin
            w_bp_clip = (w_bp_full > 12'd511) ? 9'd511 : w_bp_full[8:0];
        end
        w_act = (w_hpos < r_cur_rise) ? 12'd0 : w_hpos - r_cur_rise;
        // A line without DE only feeds total/synclen until the field has seen its first DE line
        w_hs_upd     = w_hs_fall & (r_cur_de | ~r_f_de_seen);
        w_de_upd     = w_hs_fall & r_cur_de;
        w_nx_htotal  = w_hs_upd ? w_hpos_inc : r_f_htotal;
        w_nx_synclen = w_hs_upd ? r_cur_synclen : r_f_synclen;
        w_nx_bp      = w_de_upd ? r_cur_bp : r_f_bp;
        w_nx_active  = w_de_upd ? r_cur_active : r_f_active;
        w_vbp_full   = r_f_first - {7'd0, r_f_vsync};
        if (!r_f_de_seen || (r_f_first < {7'd0, r_f_vsync})) begin
            w_vbp_cap = 9'd0;
        end else begin
            w_vbp_cap = (w_vbp_full > 11'd511) ? 9'd511 : w_vbp_full[8:0];
        end
    end

    // Field-to-field comparison feeding interlace and the stability counter
    always_comb begin
        w_vt_diff1 = ({1'b0, r_s_vtotal} == ({1'b0, v_total} + 12'd1)) ||
                     ({1'b0, v_total} == ({1'b0, r_s_vtotal} + 12'd1));
        w_vt_match = (r_s_vtotal == v_total) || (interlace && w_vt_diff1);
        w_same     = meas_valid && w_vt_match &&
                     (r_s_htotal == h_total) && (r_s_synclen == h_synclen) &&
                     (r_s_bp == h_backporch) && (r_s_active == h_active) &&
                     (r_s_vsync == v_synclen) && (r_s_vbp == v_backporch) &&
                     (r_s_vactive == v_active);
        if (w_same) begin
            w_match_nx = (r_match == 4'd15) ? r_match : r_match + 4'd1;
        end else begin
            w_match_nx = 4'd0;
        end
    end

    // Measurement datapath: edge history, line/field accumulators and the closing-field snapshot
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_hs_prev     <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_de_prev     <= 1'b0;
            r_hpos        <= 12'd0;
            r_vline       <= 11'd0;
            r_vs_pend     <= 1'b0;
            r_cur_synclen <= 8'd0;
            r_cur_bp      <= 9'd0;
            r_cur_rise    <= 12'd0;
            r_cur_active  <= 12'd0;
            r_cur_de      <= 1'b0;
            r_f_htotal    <= 12'd0;
            r_f_synclen   <= 8'd0;
            r_f_bp        <= 9'd0;
            r_f_active    <= 12'd0;
            r_f_de_seen   <= 1'b0;
            r_f_first     <= 11'd0;
            r_f_vactive   <= 11'd0;
            r_f_vsync     <= 4'd0;
            r_s_htotal    <= 12'd0;
            r_s_synclen   <= 8'd0;
            r_s_bp        <= 9'd0;
            r_s_active    <= 12'd0;
            r_s_vtotal    <= 11'd0;
            r_s_vsync     <= 4'd0;
            r_s_vbp       <= 9'd0;
            r_s_vactive   <= 11'd0;
            r_close       <= 1'b0;
            r_vs_fall_d   <= 1'b0;
        end else begin
            r_hs_prev   <= HSYNC_i;
            r_vs_prev   <= VSYNC_i;
            r_de_prev   <= DE_i;
            r_hpos      <= w_hpos;
            r_vline     <= w_vline;
            r_vs_fall_d <= w_vs_fall;
            r_close     <= w_vs_fall && enable && (r_state == S_RUN);
            if (w_vs_fall && !w_hs_fall) begin
                r_vs_pend <= 1'b1;
            end else if (w_hs_fall) begin
                r_vs_pend <= 1'b0;
            end
            if (w_hs_fall) begin
                r_cur_synclen <= 8'd0;
                r_cur_bp      <= 9'd0;
                r_cur_rise    <= 12'd0;
                r_cur_active  <= 12'd0;
                r_cur_de      <= 1'b0;
            end
            if (w_hs_rise) begin
                r_cur_synclen <= w_sync_clip;
            end
            if (w_de_rise && !r_cur_de) begin
                r_cur_de   <= 1'b1;
                r_cur_rise <= w_hpos;
                r_cur_bp   <= w_bp_clip;
            end
            if (w_de_fall && r_cur_de) begin
                r_cur_active <= w_act;
            end
            if (w_vs_fall) begin
                r_s_htotal  <= w_nx_htotal;
                r_s_synclen <= w_nx_synclen;
                r_s_bp      <= w_nx_bp;
                r_s_active  <= w_nx_active;
                r_s_vtotal  <= w_vline_inc;
                r_s_vsync   <= r_f_vsync;
                r_s_vbp     <= w_vbp_cap;
                r_s_vactive <= r_f_vactive;
                r_f_htotal  <= 12'd0;
                r_f_synclen <= 8'd0;
                r_f_bp      <= 9'd0;
                r_f_active  <= 12'd0;
                r_f_de_seen <= 1'b0;
                r_f_first   <= 11'd0;
                r_f_vactive <= 11'd0;
                r_f_vsync   <= w_hs_fall ? 4'd1 : 4'd0;
            end else begin
                r_f_htotal  <= w_nx_htotal;
                r_f_synclen <= w_nx_synclen;
                r_f_bp      <= w_nx_bp;
                r_f_active  <= w_nx_active;
                if (w_hs_fall && !VSYNC_i && (r_f_vsync != 4'd15)) begin
                    r_f_vsync <= r_f_vsync + 4'd1;
                end
                if (w_de_rise && !r_f_de_seen) begin
                    r_f_de_seen <= 1'b1;
                    r_f_first   <= w_vline;
                end
                if (w_de_rise && !r_cur_de && (r_f_vactive != 11'd2047)) begin
                    r_f_vactive <= r_f_vactive + 11'd1;
                end
            end
        end
    end

    // Control FSM, watchdog and the published result registers
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_match     <= 4'd0;
            r_wdog      <= '0;
            h_total     <= 12'd0;
            h_synclen   <= 8'd0;
            h_backporch <= 9'd0;
            h_active    <= 12'd0;
            v_total     <= 11'd0;
            v_synclen   <= 4'd0;
            v_backporch <= 9'd0;
            v_active    <= 11'd0;
            interlace   <= 1'b0;
            meas_valid  <= 1'b0;
            stable      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || w_vs_fall) begin
                r_wdog <= '0;
            end else if (r_wdog != WD_MAX) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (!enable) begin
                r_state <= S_IDLE;
                stable  <= 1'b0;
                r_match <= 4'd0;
            end else if (w_wdog_hit) begin
                r_state    <= S_WAIT_VS;
                timeout    <= 1'b1;
                stable     <= 1'b0;
                meas_valid <= 1'b0;
                r_match    <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE:    r_state <= S_WAIT_VS;
                    S_WAIT_VS: r_state <= w_vs_fall ? S_RUN : S_WAIT_VS;
                    S_RUN:     r_state <= S_RUN;
                    default:   r_state <= S_IDLE;
                endcase
                if (r_vs_fall_d) begin
                    timeout <= 1'b0;
                end
                if (r_close) begin
                    h_total     <= r_s_htotal;
                    h_synclen   <= r_s_synclen;
                    h_backporch <= r_s_bp;
                    h_active    <= r_s_active;
                    v_total     <= r_s_vtotal;
                    v_synclen   <= r_s_vsync;
                    v_backporch <= r_s_vbp;
                    v_active    <= r_s_vactive;
                    meas_valid  <= 1'b1;
                    interlace   <= meas_valid && w_vt_diff1;
                    r_match     <= w_match_nx;
                    stable      <= (w_match_nx >= STABLE_N);
                end
            end
        end
    end

endmodule
